// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-transmitter handshake bundle for uart_tx_arbiter.
// master = requesters plus UART side (stimulus), slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_LAST;
  logic [NUM_REQ-1:0]   REQ_READY;
  logic                 TX_VALID;
  logic [7:0]           TX_DATA;
  logic                 TX_READY;
  logic [NUM_REQ-1:0]   GRANT;
  logic                 BUSY;
  logic                 ABORT;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
    input  REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY, ABORT
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
    output REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY, ABORT
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte path, with an inter-packet gap.
// Optional stall abort is enabled by defining UART_TX_ARB_STALL_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              FAB_CLK,
  input logic              RESET,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PKT, GAP} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [IDX_W-1:0]   grant_idx_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               busy_reg;
  logic               abort_reg;

  logic [IDX_W-1:0]   winner_idx;
  logic [IDX_W-1:0]   cand;
  logic               winner_found;
  logic               in_pkt;
  logic               tx_valid;
  logic               transfer;
  logic               pkt_end;
  logic               stall_hit;
  logic [NUM_REQ-1:0] req_ready;

  // Scan downward so the candidate closest to rr_ptr+1 is the last, winning assignment.
  always_comb begin
    winner_idx   = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(rr_ptr_reg) + off) % NUM_REQ);
      if (bus.REQ_VALID[cand]) begin
        winner_idx   = cand;
        winner_found = 1'b1;
      end
    end
  end

  assign in_pkt   = (state_reg == PKT);
  assign tx_valid = in_pkt & bus.REQ_VALID[grant_idx_reg];
  assign transfer = tx_valid & bus.TX_READY;
  assign pkt_end  = transfer & bus.REQ_LAST[grant_idx_reg];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = in_pkt & grant_reg[gi] & bus.TX_READY;
  end

  assign bus.REQ_READY = req_ready;
  assign bus.TX_VALID  = tx_valid;
  assign bus.TX_DATA   = in_pkt ? bus.REQ_DATA[{grant_idx_reg, 3'b000} +: 8] : 8'h00;
  assign bus.GRANT     = grant_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.ABORT     = abort_reg;

`ifdef UART_TX_ARB_STALL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] stall_cnt_reg;

  assign stall_hit = in_pkt && !transfer && (stall_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge FAB_CLK) begin
    if (RESET || !in_pkt || transfer) begin
      stall_cnt_reg <= '0;
    end else if (!stall_hit) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign stall_hit      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
      gap_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (winner_found) begin
            grant_reg     <= NUM_REQ'(1) << winner_idx;
            grant_idx_reg <= winner_idx;
            rr_ptr_reg    <= winner_idx;
            state_reg     <= PKT;
            busy_reg      <= 1'b1;
          end
        end
        PKT: begin
          // A stall abort closes the packet exactly like a LAST transfer.
          if (pkt_end || stall_hit) begin
            abort_reg <= stall_hit;
            grant_reg <= '0;
            if (GAP_CYCLES > 0) begin
              state_reg   <= GAP;
              gap_cnt_reg <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          grant_reg <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench: dut uses GAP_CYCLES=16/TIMEOUT_CYCLES=8, dut_nogap uses GAP_CYCLES=0.
// Inputs change 1 ns after the rising edge, outputs are sampled 2 ns after it.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) bus_b ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) dut (
    .FAB_CLK(clk),
    .RESET  (rst),
    .bus    (bus_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_nogap (
    .FAB_CLK(clk),
    .RESET  (rst),
    .bus    (bus_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    #1;
    while (bus_a.BUSY === 1'b1 && n < 40) begin
      cyc();
      #1;
      n++;
    end
    checks++;
    if (bus_a.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, bus_a.BUSY);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0 || bus_a.BUSY !== 1'b0 || bus_a.ABORT !== 1'b0 ||
        bus_a.TX_VALID !== 1'b0 || bus_a.TX_DATA !== 8'h00 || bus_a.REQ_READY !== 4'b0) begin
      errors++;
      $display("FAIL reset_a grant=%b busy=%b abort=%b txv=%b txd=%h rdy=%b required all 0",
               bus_a.GRANT, bus_a.BUSY, bus_a.ABORT, bus_a.TX_VALID, bus_a.TX_DATA, bus_a.REQ_READY);
    end
    checks++;
    if (bus_b.GRANT !== 4'b0 || bus_b.BUSY !== 1'b0 || bus_b.TX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_b grant=%b busy=%b txv=%b required all 0",
               bus_b.GRANT, bus_b.BUSY, bus_b.TX_VALID);
    end
    $display("reset released");
    cyc();
  endtask

  task automatic test_single();
    logic [7:0] bytes [3] = '{8'hA1, 8'hA2, 8'hA3};
    int gap_len = 0;
    bit gap_grant_bad = 0;
    bus_a.REQ_VALID = 4'b0010;
    bus_a.REQ_DATA  = {16'h0, bytes[0], 8'h00};
    bus_a.REQ_LAST  = 4'b0000;
    bus_a.TX_READY  = 1'b1;
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant_early grant=%b required 0000", bus_a.GRANT);
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      bus_a.REQ_DATA = {16'h0, bytes[k], 8'h00};
      bus_a.REQ_LAST = (k == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (bus_a.GRANT !== 4'b0010 || bus_a.TX_VALID !== 1'b1 || bus_a.TX_DATA !== bytes[k] ||
          bus_a.REQ_READY !== 4'b0010 || bus_a.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL single_byte%0d grant=%b txv=%b txd=%h rdy=%b busy=%b required 0010 1 %h 0010 1",
                 k, bus_a.GRANT, bus_a.TX_VALID, bus_a.TX_DATA, bus_a.REQ_READY, bus_a.BUSY, bytes[k]);
      end
      $display("single tx byte %h", bus_a.TX_DATA);
      cyc();
    end
    bus_a.REQ_VALID = 4'b0;
    bus_a.REQ_LAST  = 4'b0;
    #1;
    while (bus_a.BUSY === 1'b1 && gap_len < 40) begin
      if (bus_a.GRANT !== 4'b0 || bus_a.TX_VALID !== 1'b0) gap_grant_bad = 1;
      gap_len++;
      cyc();
      #1;
    end
    checks++;
    if (gap_len != 16) begin
      errors++;
      $display("FAIL single_gap_len got %0d required 16", gap_len);
    end
    checks++;
    if (gap_grant_bad) begin
      errors++;
      $display("FAIL single_gap_grant grant/txvalid nonzero during gap, required 0");
    end
    checks++;
    if (bus_a.BUSY !== 1'b0 || bus_a.GRANT !== 4'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b grant=%b required 0 0000", bus_a.BUSY, bus_a.GRANT);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int got [5] = '{default: -1};
    int n = 0;
    int idx;
    bus_b.REQ_VALID = 4'b1111;
    bus_b.REQ_LAST  = 4'b1111;
    bus_b.REQ_DATA  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus_b.TX_READY  = 1'b1;
    for (int t = 0; t < 20 && n < 5; t++) begin
      #1;
      if (bus_b.GRANT !== 4'b0) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (bus_b.GRANT[i]) idx = i;
        got[n] = idx;
        checks++;
        if (bus_b.TX_DATA !== 8'(8'h10 + idx)) begin
          errors++;
          $display("FAIL rr_data%0d got %h required %h", n, bus_b.TX_DATA, 8'(8'h10 + idx));
        end
        $display("rr grant %0d tx byte %h", idx, bus_b.TX_DATA);
        n++;
      end
      cyc();
    end
    bus_b.REQ_VALID = 4'b0;
    bus_b.REQ_LAST  = 4'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order%0d got %0d required %0d", i, got[i], exp_order[i]);
      end
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_rdy [4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100};
    logic [7:0] bytes [2] = '{8'hB0, 8'hB1};
    logic [7:0] rx [$];
    int idx = 0;
    bus_a.REQ_VALID = 4'b0100;
    bus_a.REQ_DATA  = {8'h00, bytes[0], 16'h0};
    bus_a.REQ_LAST  = 4'b0000;
    bus_a.TX_READY  = 1'b1;
    cyc();
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant got %b required 0100", bus_a.GRANT);
    end
    for (int k = 0; k < 4; k++) begin
      bus_a.TX_READY = pat[k];
      bus_a.REQ_DATA = {8'h00, bytes[idx], 16'h0};
      bus_a.REQ_LAST = (idx == 1) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (bus_a.REQ_READY !== exp_rdy[k] || bus_a.TX_DATA !== bytes[idx]) begin
        errors++;
        $display("FAIL bp_cycle%0d rdy=%b txd=%h required %b %h",
                 k, bus_a.REQ_READY, bus_a.TX_DATA, exp_rdy[k], bytes[idx]);
      end
      if (bus_a.REQ_READY[2] === 1'b1 && bus_a.TX_VALID === 1'b1) begin
        rx.push_back(bus_a.TX_DATA);
        $display("bp tx byte %h", bus_a.TX_DATA);
        idx++;
      end
      cyc();
    end
    bus_a.REQ_VALID = 4'b0;
    bus_a.REQ_LAST  = 4'b0;
    bus_a.TX_READY  = 1'b1;
    #1;
    checks++;
    if (rx.size() != 2 || rx[0] !== 8'hB0 || rx[1] !== 8'hB1) begin
      errors++;
      $display("FAIL bp_bytes got count %0d required 2 bytes B0 B1", rx.size());
    end
    checks++;
    if (bus_a.BUSY !== 1'b1 || bus_a.GRANT !== 4'b0) begin
      errors++;
      $display("FAIL bp_gap busy=%b grant=%b required 1 0000", bus_a.BUSY, bus_a.GRANT);
    end
    wait_idle_a("bp");
  endtask

  task automatic test_competition();
    int gap_len = 0;
    bit stolen = 0;
    bus_a.REQ_VALID = 4'b1000;
    bus_a.REQ_DATA  = {8'hC0, 24'h0};
    bus_a.REQ_LAST  = 4'b0000;
    bus_a.TX_READY  = 1'b1;
    cyc();
    bus_a.REQ_VALID = 4'b1001;
    bus_a.REQ_DATA  = {8'hC1, 16'h0, 8'hD0};
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b1000 || bus_a.REQ_READY !== 4'b1000 || bus_a.TX_DATA !== 8'hC1) begin
      errors++;
      $display("FAIL comp_owner grant=%b rdy=%b txd=%h required 1000 1000 c1",
               bus_a.GRANT, bus_a.REQ_READY, bus_a.TX_DATA);
    end
    $display("comp tx byte %h", bus_a.TX_DATA);
    cyc();
    bus_a.REQ_DATA = {8'hC2, 16'h0, 8'hD0};
    bus_a.REQ_LAST = 4'b1000;
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b1000 || bus_a.TX_DATA !== 8'hC2) begin
      errors++;
      $display("FAIL comp_last grant=%b txd=%h required 1000 c2", bus_a.GRANT, bus_a.TX_DATA);
    end
    $display("comp tx byte %h", bus_a.TX_DATA);
    cyc();
    bus_a.REQ_VALID = 4'b0001;
    bus_a.REQ_LAST  = 4'b0000;
    #1;
    while (bus_a.BUSY === 1'b1 && gap_len < 40) begin
      if (bus_a.GRANT !== 4'b0) stolen = 1;
      gap_len++;
      cyc();
      #1;
    end
    checks++;
    if (gap_len != 16 || stolen) begin
      errors++;
      $display("FAIL comp_gap len=%0d grant_seen=%0d required 16 0", gap_len, stolen);
    end
    checks++;
    if (bus_a.GRANT !== 4'b0000) begin
      errors++;
      $display("FAIL comp_idle_visit grant=%b required 0000", bus_a.GRANT);
    end
    cyc();
    bus_a.REQ_LAST = 4'b0001;
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0001 || bus_a.TX_DATA !== 8'hD0) begin
      errors++;
      $display("FAIL comp_req0_grant grant=%b txd=%h required 0001 d0", bus_a.GRANT, bus_a.TX_DATA);
    end
    $display("comp tx byte %h", bus_a.TX_DATA);
    cyc();
    bus_a.REQ_VALID = 4'b0;
    bus_a.REQ_LAST  = 4'b0;
    wait_idle_a("comp");
  endtask

  task automatic test_reset_mid_packet();
    bus_a.REQ_VALID = 4'b0010;
    bus_a.REQ_DATA  = {16'h0, 8'hE1, 8'h00};
    bus_a.REQ_LAST  = 4'b0000;
    bus_a.TX_READY  = 1'b1;
    cyc();
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_grant got %b required 0010", bus_a.GRANT);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus_a.REQ_VALID = 4'b0101;
    bus_a.REQ_DATA  = {8'h00, 8'hF2, 8'h00, 8'hF0};
    #1;
    checks++;
    if (bus_a.TX_VALID !== 1'b0 || bus_a.GRANT !== 4'b0 || bus_a.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear txv=%b grant=%b busy=%b required 0 0000 0",
               bus_a.TX_VALID, bus_a.GRANT, bus_a.BUSY);
    end
    cyc();
    bus_a.REQ_LAST = 4'b0001;
    #1;
    checks++;
    if (bus_a.GRANT !== 4'b0001 || bus_a.TX_DATA !== 8'hF0) begin
      errors++;
      $display("FAIL rstmid_rr grant=%b txd=%h required 0001 f0", bus_a.GRANT, bus_a.TX_DATA);
    end
    $display("rstmid tx byte %h", bus_a.TX_DATA);
    cyc();
    bus_a.REQ_VALID = 4'b0;
    bus_a.REQ_LAST  = 4'b0;
    wait_idle_a("rstmid");
  endtask

  task automatic test_stall();
    int abort_cnt = 0;
    int abort_t   = -1;
    bit abort_bad = 0;
    bit grant_bad = 0;
    bus_a.REQ_VALID = 4'b0010;
    bus_a.REQ_DATA  = {16'h0, 8'h55, 8'h00};
    bus_a.REQ_LAST  = 4'b0000;
    bus_a.TX_READY  = 1'b1;
    cyc();
    bus_a.REQ_VALID = 4'b0000;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (bus_a.ABORT === 1'b1) begin
        abort_cnt++;
        abort_t = t;
        if (bus_a.GRANT !== 4'b0 || bus_a.BUSY !== 1'b1) abort_bad = 1;
      end
      if (t < 8 && bus_a.GRANT !== 4'b0010) grant_bad = 1;
      cyc();
    end
`ifdef UART_TX_ARB_STALL_TIMEOUT_EN
    checks++;
    if (abort_cnt != 1 || abort_t != 8 || abort_bad || grant_bad) begin
      errors++;
      $display("FAIL stall_abort count=%0d at=%0d bad=%0d grant_bad=%0d required 1 8 0 0",
               abort_cnt, abort_t, abort_bad, grant_bad);
    end
    $display("stall abort seen at cycle %0d", abort_t);
`else
    checks++;
    if (abort_cnt != 0 || bus_a.GRANT !== 4'b0010 || grant_bad) begin
      errors++;
      $display("FAIL stall_hold aborts=%0d grant=%b required 0 0010", abort_cnt, bus_a.GRANT);
    end
    $display("stall held grant %b", bus_a.GRANT);
    bus_a.REQ_VALID = 4'b0010;
    bus_a.REQ_LAST  = 4'b0010;
    cyc();
    bus_a.REQ_VALID = 4'b0;
    bus_a.REQ_LAST  = 4'b0;
`endif
    wait_idle_a("stall");
  endtask

  initial begin
    bus_a.REQ_VALID = '0; bus_a.REQ_DATA = '0; bus_a.REQ_LAST = '0; bus_a.TX_READY = 1'b0;
    bus_b.REQ_VALID = '0; bus_b.REQ_DATA = '0; bus_b.REQ_LAST = '0; bus_b.TX_READY = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_competition();
    test_reset_mid_packet();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single fabric-side UART_0 byte transmit path among NUM_REQ requesters, for example the screen renderer, debug logger and command responder. Arbitration is round-robin at packet granularity. Once a requester is granted, it owns the transmitter until it hands over a byte flagged LAST. Each packet is followed by a fixed inter-packet gap so the controller-screen receiver can resynchronise. The block sits between the fabric requesters and the UART TX byte interface of final_mss.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle FAB_CLK cycles inserted after each packet (0 = no gap)
TIMEOUT_CYCLES, 1024, stall limit in cycles; used only with STALL_TIMEOUT_EN

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  NUM_REQ  requester i offers a byte
REQ_DATA  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
REQ_LAST  in  NUM_REQ  offered byte is the last byte of the packet
REQ_READY  out  NUM_REQ  byte of requester i accepted this cycle
TX_VALID  out  1  byte valid to UART transmitter
TX_DATA  out  8  byte to UART transmitter
TX_READY  in  1  UART transmitter accepts the byte
GRANT  out  NUM_REQ  one-hot owner, registered
BUSY  out  1  high in PKT or GAP
ABORT  out  1  one-cycle stall-abort pulse (feature only)

Behaviour:
- Reset is synchronous and active-high on FAB_CLK. It sets state IDLE, GRANT=0, BUSY=0, ABORT=0 and rr_ptr=NUM_REQ-1, so requester 0 wins first. TX_VALID, TX_DATA and REQ_READY are 0 in the cycle after reset.
- FSM states: IDLE, PKT, GAP.
- IDLE: if any REQ_VALID bit is set, choose the first set bit scanning from (rr_ptr+1) mod NUM_REQ upward, with wrap-around. At the clock edge: GRANT=onehot(winner), rr_ptr=winner, state->PKT. Grant latency is one cycle from REQ_VALID.
- PKT, with g the granted index, is combinational passthrough:
  - TX_VALID = REQ_VALID[g]
  - TX_DATA = REQ_DATA[g]
  - REQ_READY[g] = TX_READY
  - all other REQ_READY bits are 0
- Outside PKT: TX_VALID=0, TX_DATA=0, all REQ_READY=0.
- Transfer occurs when TX_VALID & TX_READY. A transfer with REQ_LAST[g]=1 ends the packet:
  - if GAP_CYCLES>0: GRANT->0, gap counter loads GAP_CYCLES-1, state->GAP;
  - if GAP_CYCLES=0: state->IDLE.
- A requester dropping REQ_VALID mid-packet does not release the grant. Other requesters' VALID is ignored in PKT and GAP.
- GAP: counter decrements each cycle and the state moves to IDLE in the cycle after the counter reads 0. This gives exactly GAP_CYCLES cycles with BUSY=1 and GRANT=0.
- A single-byte packet (LAST on the first byte) is legal: PKT lasts 1 cycle if TX_READY is high.
- If REQ_VALID is high in IDLE the same cycle GAP ends, arbitration happens in the next cycle (IDLE is always visited).
- RESET asserted mid-packet aborts at once. No partial-packet state is kept, and rr_ptr returns to NUM_REQ-1.
- BUSY = (state != IDLE), registered.

Optional Feature:
Macro: UART_TX_ARB_STALL_TIMEOUT_EN.
- Defined: in PKT a stall counter counts cycles without a transfer and clears on every transfer. When it reaches TIMEOUT_CYCLES-1 with no transfer: ABORT=1 for one cycle, GRANT->0, and the packet ends as if LAST had been sent (the GAP rules apply).
- Undefined: no counter, ABORT tied to 0, and a stalled requester holds the grant indefinitely.

Test Plan:
- Single requester: REQ_VALID[1]=1, 3 bytes 0xA1,0xA2,0xA3 (LAST on 3rd), TX_READY=1 -> GRANT=0b0010 one cycle after VALID; TX_DATA sequence A1,A2,A3 on consecutive cycles; then BUSY high for 16 GAP cycles with GRANT=0; then IDLE.
- All four requesting continuously, 1-byte packets, GAP_CYCLES=0 -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Backpressure: TX_READY toggled 1,0,0,1 during packet from req 2 -> REQ_READY[2] mirrors TX_READY; no byte lost or duplicated; other REQ_READY stay 0.
- Mid-packet competition: req 3 granted and sending; req 0 asserts VALID -> req 0 not granted until req 3's LAST transfer plus gap.
- RESET pulsed for 1 cycle mid-packet -> next cycle TX_VALID=0, GRANT=0, BUSY=0; next arbitration with req 0 and req 2 both valid picks req 0.
- With UART_TX_ARB_STALL_TIMEOUT_EN and TIMEOUT_CYCLES=8: granted requester holds VALID=0 for 8 cycles -> ABORT pulses once, GRANT->0, BUSY stays high through the gap.
